// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: widths, RV32I funct3 width
// codes, FSM state type and the request legality check.
package lsu_pkg;

  localparam int XLEN   = 32;
  localparam int STRB_W = XLEN / 8;

  // RV32I funct3 width/sign codes (loads use all five, stores only B/H/W)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  // A request is legal when funct3 names a width that exists for the access
  // direction and the address is naturally aligned for that width.
  function automatic logic f3_legal(input logic       we,
                                    input logic [2:0] f3,
                                    input logic [1:0] off);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~off[0];
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = ~we;
      F3_HU:   ok = ~we & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Bus bundles around the load/store unit: the core-facing request/response
// channel and the data-memory channel.
interface lsu_req_if;
  import lsu_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;

  // core side
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  // load/store unit side
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface lsu_mem_if;
  import lsu_pkg::*;

  logic              mem_valid;
  logic              mem_ready;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [STRB_W-1:0] mem_wstrb;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  // load/store unit side
  modport master (
    output mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  // memory side
  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit. Purely combinational:
// store data is replicated across lanes with matching strobes, load data
// is picked from its lane and sign- or zero-extended.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        off_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [XLEN-1:0]   rdata_i,
  output logic [STRB_W-1:0] wstrb_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic [XLEN-1:0]   rdata_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_byte = rdata_i[{off_i, 3'b000} +: 8];
  assign ld_half = rdata_i[{off_i[1], 4'b0000} +: 16];

  // Store path: replicate the low byte/halfword into every lane so the
  // strobes alone select where it lands.
  always_comb begin
    wstrb_o = '0;
    wdata_o = wdata_i;
    case (funct3_i)
      F3_B: begin
        wdata_o = {4{wdata_i[7:0]}};
        wstrb_o = 4'b0001 << off_i;
      end
      F3_H: begin
        wdata_o = {2{wdata_i[15:0]}};
        wstrb_o = 4'b0011 << off_i;
      end
      F3_W: begin
        wstrb_o = 4'b1111;
      end
      default: begin
        wstrb_o = '0;
      end
    endcase
  end

  // Load path: extend the selected lane to a full register value.
  always_comb begin
    rdata_o = '0;
    case (funct3_i)
      F3_B:    rdata_o = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    rdata_o = {{16{ld_half[15]}}, ld_half};
      F3_W:    rdata_o = rdata_i;
      F3_BU:   rdata_o = {24'h000000, ld_byte};
      F3_HU:   rdata_o = {16'h0000, ld_half};
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one load/store from the core, performs a single
// word-aligned memory access and returns extended load data or an error.
// All outputs come from registers or the state decode, so nothing on the
// memory inputs reaches the response outputs combinationally.
module lsu
  import lsu_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  lsu_req_if.slave  req,
  lsu_mem_if.master mem
);

  lsu_state_t      state_q,  state_d;
  logic [XLEN-1:0] addr_q,   addr_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            we_q,     we_d;
  logic [XLEN-1:0] wdata_q,  wdata_d;
  logic [XLEN-1:0] rdata_q,  rdata_d;
  logic            err_q,    err_d;

  logic [STRB_W-1:0] st_wstrb;
  logic [XLEN-1:0]   st_wdata;
  logic [XLEN-1:0]   ld_data;
  logic              in_req;

  lsu_align u_align (
    .funct3_i (funct3_q),
    .off_i    (addr_q[1:0]),
    .wdata_i  (wdata_q),
    .rdata_i  (mem.mem_rdata),
    .wstrb_o  (st_wstrb),
    .wdata_o  (st_wdata),
    .rdata_o  (ld_data)
  );

  // State and transaction registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic: accept, issue, wait for read data, respond.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (req.req_valid) begin
          addr_d   = req.req_addr;
          funct3_d = req.req_funct3;
          we_d     = req.req_we;
          wdata_d  = req.req_wdata;
          rdata_d  = '0;
          if (f3_legal(req.req_we, req.req_funct3, req.req_addr[1:0])) begin
            err_d   = 1'b0;
            state_d = REQ;
          end else begin
            // illegal requests skip memory entirely
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      REQ: begin
        if (mem.mem_ready) begin
          state_d = we_q ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (mem.mem_rvalid) begin
          rdata_d = ld_data;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_req = (state_q == REQ);

  assign req.req_ready  = (state_q == IDLE);
  assign req.resp_valid = (state_q == RESP);
  assign req.resp_err   = (state_q == RESP) & err_q;
  assign req.resp_rdata = (state_q == RESP) ? rdata_q : '0;

  assign mem.mem_valid = in_req;
  assign mem.mem_we    = in_req & we_q;
  assign mem.mem_addr  = in_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign mem.mem_wstrb = (in_req && we_q) ? st_wstrb : '0;
  assign mem.mem_wdata = (in_req && we_q) ? st_wdata : '0;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for the load/store unit with a response scoreboard and a
// small memory responder with programmable ready/read-data delays.
module tb_lsu;
  import lsu_pkg::*;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          acc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;

  exp_t exp_q[$];

  // memory responder configuration / expectations
  int          cfg_rdy;
  int          cfg_rv;
  logic [31:0] cfg_rdata;
  int          stray_cnt;
  logic        exp_mem;
  logic [31:0] exp_maddr;
  logic        exp_we;
  logic [3:0]  exp_wstrb;
  logic [31:0] exp_wdata;

  lsu_req_if req_bus ();
  lsu_mem_if mem_bus ();

  lsu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_bus),
    .mem   (mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic legal_tb(input logic we, input logic [2:0] f3, input logic [1:0] off);
    logic [1:0] sz;
    sz = f3[1:0];
    if (sz == 2'd3) return 1'b0;
    if (f3[2] && (sz == 2'd2 || we)) return 1'b0;
    if (sz == 2'd0) return 1'b1;
    if (sz == 2'd1) return ~off[0];
    return off == 2'd0;
  endfunction

  task automatic exp_fmt(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] wd,
                         output logic [3:0] strb, output logic [31:0] w);
    strb = 4'h0;
    w    = 32'h0;
    for (int i = 0; i < 4; i++) begin
      case (f3[1:0])
        2'd0:    w[8*i +: 8] = wd[7:0];
        2'd1:    w[8*i +: 8] = wd[8*(i%2) +: 8];
        default: w[8*i +: 8] = wd[8*i +: 8];
      endcase
    end
    case (f3[1:0])
      2'd0: strb[off] = 1'b1;
      2'd1: begin strb[off] = 1'b1; strb[int'(off)+1] = 1'b1; end
      default: strb = 4'hF;
    endcase
  endtask

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rd);
    logic [31:0] sh;
    logic [31:0] v;
    sh = rd >> (8 * off);
    case (f3[1:0])
      2'd0: begin
        v = {24'h0, sh[7:0]};
        if (!f3[2] && sh[7]) v = v | 32'hFFFF_FF00;
      end
      2'd1: begin
        v = {16'h0, sh[15:0]};
        if (!f3[2] && sh[15]) v = v | 32'hFFFF_0000;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  // Memory responder: checks every cycle of a memory request, raises ready
  // after cfg_rdy cycles and returns read data cfg_rv cycles after a load
  // handshake.
  initial begin : mem_model
    int   rdy_cnt;
    int   rv_cnt;
    logic rv_pend;
    rdy_cnt = 0;
    rv_cnt  = 0;
    rv_pend = 1'b0;
    mem_bus.mem_ready  = 1'b0;
    mem_bus.mem_rvalid = 1'b0;
    mem_bus.mem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      mem_bus.mem_rdata  = cfg_rdata;
      mem_bus.mem_rvalid = 1'b0;
      if (!rst_n) begin
        mem_bus.mem_ready = 1'b0;
        rdy_cnt = 0;
        rv_cnt  = 0;
        rv_pend = 1'b0;
      end else begin
        if (stray_cnt > 0) begin
          mem_bus.mem_rvalid = 1'b1;
          stray_cnt--;
        end
        if (rv_pend) begin
          if (rv_cnt == 0) begin
            mem_bus.mem_rvalid = 1'b1;
            rv_pend = 1'b0;
          end else begin
            rv_cnt--;
          end
        end
        if (mem_bus.mem_valid) begin
          if (exp_mem) begin
            chk("mem_addr", mem_bus.mem_addr, exp_maddr);
            chk("mem_we", {31'h0, mem_bus.mem_we}, {31'h0, exp_we});
            chk("mem_wstrb", {28'h0, mem_bus.mem_wstrb}, {28'h0, exp_wstrb});
            if (exp_we) chk("mem_wdata", mem_bus.mem_wdata, exp_wdata);
          end else begin
            chk("mem_valid_unexpected", {31'h0, mem_bus.mem_valid}, 32'h0);
          end
          if (rdy_cnt >= cfg_rdy) begin
            mem_bus.mem_ready = 1'b1;
            rdy_cnt = 0;
            if (!mem_bus.mem_we) begin
              rv_pend = 1'b1;
              rv_cnt  = cfg_rv;
            end
          end else begin
            mem_bus.mem_ready = 1'b0;
            rdy_cnt++;
          end
        end else begin
          mem_bus.mem_ready = 1'b0;
          rdy_cnt = 0;
        end
      end
    end
  end

  // Response monitor: every resp_valid pulse must match the oldest expectation.
  initial begin : resp_mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && req_bus.resp_valid) begin
        chk("resp_expected", {31'h0, exp_q.size() != 0}, 32'h1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("resp_err", {31'h0, req_bus.resp_err}, {31'h0, e.err});
          chk("resp_rdata", req_bus.resp_rdata, e.rdata);
          chk("resp_latency", cyc - e.acc, e.lat);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One transaction, entered and left on a falling edge.
  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input int rdy, input int rv);
    exp_t        e;
    logic        legal;
    logic [3:0]  s;
    logic [31:0] w;
    logic        done;
    legal = legal_tb(we, f3, addr[1:0]);
    exp_fmt(f3, addr[1:0], wd, s, w);
    cfg_rdy   = rdy;
    cfg_rv    = rv;
    cfg_rdata = rd;
    exp_mem   = legal;
    exp_maddr = {addr[31:2], 2'b00};
    exp_we    = we;
    exp_wstrb = (legal && we) ? s : 4'h0;
    exp_wdata = w;
    e.err   = ~legal;
    e.rdata = (legal && !we) ? exp_load(f3, addr[1:0], rd) : 32'h0;
    e.lat   = !legal ? 1 : (we ? 2 + rdy : 3 + rdy + rv);
    e.acc   = cyc;
    exp_q.push_back(e);
    chk("req_ready_idle", {31'h0, req_bus.req_ready}, 32'h1);
    req_bus.req_valid  = 1'b1;
    req_bus.req_we     = we;
    req_bus.req_funct3 = f3;
    req_bus.req_addr   = addr;
    req_bus.req_wdata  = wd;
    @(negedge clk);
    // scramble the request bus so only latched values can be used
    req_bus.req_valid  = 1'b0;
    req_bus.req_we     = ~we;
    req_bus.req_funct3 = ~f3;
    req_bus.req_addr   = ~addr;
    req_bus.req_wdata  = ~wd;
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      if (req_bus.resp_valid) begin
        done = 1'b1;
        chk("ready_in_resp", {31'h0, req_bus.req_ready}, 32'h0);
      end else begin
        chk("ready_busy", {31'h0, req_bus.req_ready}, 32'h0);
        @(negedge clk);
      end
    end
    if (!done) chk("resp_timeout", {31'h0, req_bus.resp_valid}, 32'h1);
    @(negedge clk);
    chk("resp_single_pulse", {31'h0, req_bus.resp_valid}, 32'h0);
    $display("txn we=%0b f3=%03b addr=%h wdata=%h rdata=%h -> err=%0b data=%h lat=%0d",
             we, f3, addr, wd, rd, e.err, e.rdata, e.lat);
  endtask

  // Start a legal load and leave it in flight; used by the reset tests.
  task automatic start_load(input logic [31:0] addr, input int rdy, input int rv);
    exp_t e;
    cfg_rdy   = rdy;
    cfg_rv    = rv;
    cfg_rdata = 32'hCAFE_F00D;
    exp_mem   = 1'b1;
    exp_maddr = {addr[31:2], 2'b00};
    exp_we    = 1'b0;
    exp_wstrb = 4'h0;
    exp_wdata = 32'h0;
    e.err   = 1'b0;
    e.rdata = 32'hCAFE_F00D;
    e.lat   = 3 + rdy + rv;
    e.acc   = cyc;
    exp_q.push_back(e);
    req_bus.req_valid  = 1'b1;
    req_bus.req_we     = 1'b0;
    req_bus.req_funct3 = F3_W;
    req_bus.req_addr   = addr;
    req_bus.req_wdata  = 32'h0;
    @(negedge clk);
    req_bus.req_valid  = 1'b0;
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mem_valid", {31'h0, mem_bus.mem_valid}, 32'h0);
    chk("rst_req_ready", {31'h0, req_bus.req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, req_bus.resp_valid}, 32'h0);
    exp_q.delete();
    exp_mem = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    $display("txn reset pulse applied");
  endtask

  initial begin : stim
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    cfg_rdy   = 0;
    cfg_rv    = 0;
    cfg_rdata = 32'h0;
    stray_cnt = 0;
    exp_mem   = 1'b0;
    exp_maddr = 32'h0;
    exp_we    = 1'b0;
    exp_wstrb = 4'h0;
    exp_wdata = 32'h0;
    req_bus.req_valid  = 1'b0;
    req_bus.req_we     = 1'b0;
    req_bus.req_funct3 = 3'b000;
    req_bus.req_addr   = 32'h0;
    req_bus.req_wdata  = 32'h0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_req_ready", {31'h0, req_bus.req_ready}, 32'h1);
    chk("reset_mem_valid", {31'h0, mem_bus.mem_valid}, 32'h0);
    chk("reset_resp_valid", {31'h0, req_bus.resp_valid}, 32'h0);
    chk("reset_resp_err", {31'h0, req_bus.resp_err}, 32'h0);
    chk("reset_resp_rdata", req_bus.resp_rdata, 32'h0);
    chk("reset_mem_addr", mem_bus.mem_addr, 32'h0);
    chk("reset_mem_wstrb", {28'h0, mem_bus.mem_wstrb}, 32'h0);
    chk("reset_mem_we", {31'h0, mem_bus.mem_we}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // stores
    do_txn(1'b1, F3_W,  32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, 0);
    do_txn(1'b1, F3_B,  32'h0000_0103, 32'h0000_00A5, 32'h0, 0, 0);
    do_txn(1'b1, F3_H,  32'h0000_0102, 32'h1234_BEEF, 32'h0, 0, 0);
    do_txn(1'b1, F3_B,  32'h0000_0101, 32'h7777_773C, 32'h0, 0, 0);
    do_txn(1'b1, F3_W,  32'h0000_0504, 32'h0BAD_F00D, 32'h0, 2, 0);
    // loads
    do_txn(1'b0, F3_B,  32'h0000_0202, 32'h0, 32'h12F0_8034, 0, 0);
    do_txn(1'b0, F3_BU, 32'h0000_0202, 32'h0, 32'h12F0_8034, 0, 0);
    do_txn(1'b0, F3_HU, 32'h0000_0202, 32'h0, 32'h12F0_8034, 0, 0);
    do_txn(1'b0, F3_H,  32'h0000_0200, 32'h0, 32'h12F0_8034, 0, 0);
    do_txn(1'b0, F3_B,  32'h0000_0201, 32'h0, 32'h12F0_8034, 0, 0);
    do_txn(1'b0, F3_H,  32'h0000_0400, 32'h0, 32'h5555_8001, 3, 2);
    do_txn(1'b0, F3_W,  32'h0000_0500, 32'h0, 32'h89AB_CDEF, 1, 1);
    // illegal requests
    do_txn(1'b0, F3_W,  32'h0000_0301, 32'h0, 32'h1111_1111, 0, 0);
    do_txn(1'b0, 3'b011, 32'h0000_0300, 32'h0, 32'h1111_1111, 0, 0);
    do_txn(1'b1, F3_BU, 32'h0000_0100, 32'h55, 32'h0, 0, 0);
    do_txn(1'b1, F3_H,  32'h0000_0101, 32'h1234, 32'h0, 0, 0);
    do_txn(1'b0, F3_HU, 32'h0000_0203, 32'h0, 32'h1111_1111, 0, 0);

    // reset while the memory request is pending
    start_load(32'h0000_0600, 20, 0);
    chk("req_phase_mem_valid", {31'h0, mem_bus.mem_valid}, 32'h1);
    pulse_reset();

    // reset while waiting for read data, then a stray rvalid in IDLE
    start_load(32'h0000_0700, 0, 10);
    @(negedge clk);
    chk("wait_phase_mem_valid", {31'h0, mem_bus.mem_valid}, 32'h0);
    chk("wait_phase_req_ready", {31'h0, req_bus.req_ready}, 32'h0);
    pulse_reset();
    stray_cnt = 1;
    repeat (5) begin
      @(negedge clk);
      chk("stray_no_resp", {31'h0, req_bus.resp_valid}, 32'h0);
      chk("stray_idle", {31'h0, req_bus.req_ready}, 32'h1);
    end

    // normal operation after reset
    do_txn(1'b0, F3_BU, 32'h0000_0603, 32'h0, 32'h7F00_0000, 0, 0);
    do_txn(1'b1, F3_H,  32'h0000_0600, 32'h0000_C0DE, 32'h0, 1, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
Load/store unit in the execute/memory stage, directly downstream of the ALU. It takes the ALU result as the effective address, plus funct3 and store data (rs2). It issues one word-aligned access on a valid/ready data-memory port and returns aligned, sign- or zero-extended load data or a misalignment error to writeback. It handles one transaction at a time; the core stalls while req_ready is low.

Parameters:
XLEN, 32, data/address width (only 32 supported)
STRB_W, 4, byte strobes per word (XLEN/8)

Ports:
clk  in  1  core clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
req_valid  in  1  core presents a load/store
req_ready  out  1  unit idle, request accepted when valid&&ready
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32I width/sign code
req_addr  in  32  effective address (ALU result)
req_wdata  in  32  store data (rs2)
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  misaligned or illegal funct3; qualifies resp_valid
mem_valid  out  1  memory request
mem_ready  in  1  memory accepts request
mem_we  out  1  write enable
mem_addr  out  32  req_addr with [1:0] forced to 0
mem_wstrb  out  4  byte enables; 0 for loads
mem_wdata  out  32  lane-replicated store data
mem_rvalid  in  1  load data valid
mem_rdata  in  32  raw word read

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP. Reset puts the FSM in IDLE.
- Reset values: all outputs 0 except req_ready=1. Reset asserted mid-transaction returns the FSM to IDLE immediately and drops mem_valid without waiting for a clock. A later mem_rvalid in IDLE is ignored.
- IDLE: req_ready=1. On req_valid, latch addr, funct3, we and wdata.
  - Legal request: go to REQ.
  - Illegal request: go to RESP with err=1 and make no memory access.
- Legal loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal stores: 000 SB, 001 SH, 010 SW.
- Any other funct3 is illegal.
- Misaligned access is illegal: halfword with addr[0]=1, or word with addr[1:0]!=0.
- REQ: mem_valid=1, with mem_addr, mem_we, mem_wstrb and mem_wdata held stable until mem_ready.
  - On mem_ready, a store goes to RESP and a load goes to WAIT.
  - mem_valid drops the cycle after the handshake.
- WAIT: hold until mem_rvalid, then latch the extracted data and go to RESP. mem_rvalid is sampled only in WAIT.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. There is no response backpressure.
- req_ready=0 in REQ, WAIT and RESP. A new request can be accepted the cycle after RESP.
- Store formatting (off = addr[1:0]):
  - SB: wdata = {4{wdata[7:0]}}, wstrb = 4'b0001 << off.
  - SH: wdata = {2{wdata[15:0]}}, wstrb = 4'b0011 << off.
  - SW: wdata unchanged, wstrb = 4'b1111.
- Load extraction:
  - Byte = mem_rdata[8*off +: 8].
  - Halfword = mem_rdata[16*off[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Minimum latency (accept cycle = 0):
  - Store: RESP at cycle 2.
  - Load: RESP at cycle 3.
  - Error: RESP at cycle 1.
- Every memory wait cycle adds one cycle.
- All outputs are registered or decoded from state, with no combinational path from mem_* inputs to resp_*.

Decomposition:
- lsu_pkg: funct3 localparams (F3_B/H/W/BU/HU) and the state enum type lsu_state_t (IDLE, REQ, WAIT, RESP).
- Sub-module lsu_align: purely combinational.
  - Store path: funct3 + offset + wdata -> wstrb/wdata.
  - Load path: funct3 + offset + rdata -> extended data.
  - Instantiated once in lsu; the FSM stays in lsu.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, mem_ready=1 at once -> mem_addr=0x100, wstrb=1111, wdata=0xDEADBEEF; resp_valid at cycle 2, err=0, rdata=0.
- SB addr=0x103, wdata=0x000000A5 -> mem_addr=0x100, wstrb=1000, wdata=0xA5A5A5A5.
- LB addr=0x202, mem_rdata=0x12F08034, rvalid one cycle after accept -> resp_rdata=0xFFFFFFF0; LBU same -> 0x000000F0; LHU addr=0x202 -> 0x000012F0.
- LW addr=0x301 -> resp_valid at cycle 1 with err=1, mem_valid never asserted; funct3=011 load -> same error.
- LH addr=0x400 with mem_ready held low 3 cycles and rvalid 2 cycles later -> req_ready=0 throughout, mem_addr/wstrb stable, single resp_valid pulse, rdata = sign-extended mem_rdata[15:0].
- rst_n pulsed low during WAIT -> mem_valid=0 and req_ready=1 immediately; stray mem_rvalid afterwards produces no resp_valid.
